wf_issue_arbiter: RTL and testbench

//  Round-robin arbiter sharing one issue slot among 40 wavefront requesters.

---
 rtl/wf_issue_arbiter_pkg.sv | 12 +
 rtl/arb_lowest_one.sv | 20 ++
 rtl/wf_issue_arbiter.sv | 122 ++++++++++++
 tb/tb_wf_issue_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/wf_issue_arbiter_pkg.sv
// rtl/wf_issue_arbiter_pkg.sv - shared constants and state encoding for the wavefront issue arbiter
package wf_issue_arbiter_pkg;

   localparam int NUM_REQ = 40;
   localparam int ID_W    = 6;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_OFFER = 1'b1
   } arb_state_e;

endpackage

// File: rtl/arb_lowest_one.sv
// rtl/arb_lowest_one.sv - combinational lowest-set-bit finder returning index and any flag
import wf_issue_arbiter_pkg::*;

module arb_lowest_one (
   input  logic [NUM_REQ-1:0] vec,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   // Scan from the top so the lowest set bit is the last write.
   always_comb begin
      idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (vec[i]) idx = ID_W'(i);
      end
   end

   assign any = |vec;

endmodule

// File: rtl/wf_issue_arbiter.sv
// rtl/wf_issue_arbiter.sv - round-robin issue arbiter, 40 requesters; perf counters under WF_ARB_PERF_CNT_EN
import wf_issue_arbiter_pkg::*;

module wf_issue_arbiter (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               flush,
   input  logic               issue_ready,
   output logic               gnt_valid,
   output logic [ID_W-1:0]    gnt_id,
   output logic [NUM_REQ-1:0] gnt_onehot,
   output logic [31:0]        perf_gnt_cnt,
   output logic [31:0]        perf_stall_cnt
);

   arb_state_e         state_q, state_d;
   logic [ID_W-1:0]    last_ptr_q, last_ptr_d;
   logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
   logic [NUM_REQ-1:0] onehot_q, onehot_d;

   logic               accept;
   logic [ID_W-1:0]    base_ptr;
   logic [NUM_REQ-1:0] cand, hi_mask;
   logic [ID_W-1:0]    masked_idx, raw_idx, pick;
   logic               masked_any, raw_any;

   assign gnt_valid  = (state_q == ARB_OFFER);
   assign gnt_id     = gnt_id_q;
   assign gnt_onehot = onehot_q;
   assign accept     = gnt_valid & issue_ready;

   // On accept the search restarts just past the granted slot, excluding it.
   assign base_ptr = accept ? gnt_id_q : last_ptr_q;
   assign cand     = accept ? (req & ~onehot_q) : req;

   always_comb begin
      hi_mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         hi_mask[i] = (i > int'(base_ptr));
      end
   end

   arb_lowest_one u_masked (.vec(cand & hi_mask), .idx(masked_idx), .any(masked_any));
   arb_lowest_one u_raw    (.vec(cand),           .idx(raw_idx),    .any(raw_any));

   assign pick = masked_any ? masked_idx : raw_idx;

   always_comb begin
      state_d    = state_q;
      last_ptr_d = last_ptr_q;
      gnt_id_d   = gnt_id_q;
      onehot_d   = onehot_q;
      if (flush) begin
         state_d  = ARB_IDLE;
         gnt_id_d = '0;
         onehot_d = '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (raw_any) begin
                  state_d  = ARB_OFFER;
                  gnt_id_d = pick;
                  onehot_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
               end
            end
            ARB_OFFER: begin
               if (accept) begin
                  last_ptr_d = gnt_id_q;
                  if (raw_any) begin
                     gnt_id_d = pick;
                     onehot_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                  end else begin
                     state_d  = ARB_IDLE;
                     gnt_id_d = '0;
                     onehot_d = '0;
                  end
               end
            end
            default: state_d = ARB_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB_IDLE;
         last_ptr_q <= ID_W'(NUM_REQ - 1);
         gnt_id_q   <= '0;
         onehot_q   <= '0;
      end else begin
         state_q    <= state_d;
         last_ptr_q <= last_ptr_d;
         gnt_id_q   <= gnt_id_d;
         onehot_q   <= onehot_d;
      end
   end

`ifdef WF_ARB_PERF_CNT_EN
   logic [31:0] gnt_cnt_q, stall_cnt_q;

   // A flushed offer is dropped, so it never counts as an accepted grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (accept && !flush && gnt_cnt_q != 32'hFFFF_FFFF)
            gnt_cnt_q <= gnt_cnt_q + 32'd1;
         if (gnt_valid && !issue_ready && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign perf_gnt_cnt   = gnt_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`else
   assign perf_gnt_cnt   = 32'd0;
   assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_wf_issue_arbiter.sv
// tb/tb_wf_issue_arbiter.sv - directed self-checking bench for wf_issue_arbiter
import wf_issue_arbiter_pkg::*;

module tb_wf_issue_arbiter;

   logic               clk = 1'b0;
   logic               rst;
   logic [NUM_REQ-1:0] req;
   logic               flush;
   logic               issue_ready;
   logic               gnt_valid;
   logic [ID_W-1:0]    gnt_id;
   logic [NUM_REQ-1:0] gnt_onehot;
   logic [31:0]        perf_gnt_cnt;
   logic [31:0]        perf_stall_cnt;

   int tests = 0;
   int fails = 0;

   wf_issue_arbiter dut (
      .clk(clk), .rst(rst), .req(req), .flush(flush), .issue_ready(issue_ready),
      .gnt_valid(gnt_valid), .gnt_id(gnt_id), .gnt_onehot(gnt_onehot),
      .perf_gnt_cnt(perf_gnt_cnt), .perf_stall_cnt(perf_stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NUM_REQ-1:0] bitv(input int n);
      logic [NUM_REQ-1:0] one;
      one = 1;
      return one << n;
   endfunction

   function automatic logic [31:0] perf(input int n);
`ifdef WF_ARB_PERF_CNT_EN
      return 32'(n);
`else
      return 32'd0;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_grant(input string tag, input int id);
      chk({tag, "_valid"}, 64'(gnt_valid), 64'd1);
      chk({tag, "_id"}, 64'(gnt_id), 64'(id));
      chk({tag, "_onehot"}, 64'(gnt_onehot), 64'(bitv(id)));
   endtask

   task automatic exp_idle(input string tag);
      chk({tag, "_valid"}, 64'(gnt_valid), 64'd0);
      chk({tag, "_onehot"}, 64'(gnt_onehot), 64'd0);
   endtask

   task automatic exp_perf(input string tag, input int g, input int s);
      chk({tag, "_gnt_cnt"}, 64'(perf_gnt_cnt), 64'(perf(g)));
      chk({tag, "_stall_cnt"}, 64'(perf_stall_cnt), 64'(perf(s)));
   endtask

   initial begin
      rst = 1'b1; req = '0; flush = 1'b0; issue_ready = 1'b0;
      step(); step();
      rst = 1'b0;
      exp_idle("reset");
      chk("reset_id", 64'(gnt_id), 64'd0);
      exp_perf("reset", 0, 0);

      // single request at index 0, accepted then dropped
      req = bitv(0);
      step(); exp_grant("t1_first", 0);
      issue_ready = 1'b1; req = '0;
      step(); exp_idle("t1_done");
      exp_perf("t1", 1, 0);

      // rotation over 3, 10, 39 with wrap
      req = bitv(3) | bitv(10) | bitv(39);
      step(); exp_grant("t2_g0", 3);
      step(); exp_grant("t2_g1", 10);
      step(); exp_grant("t2_g2", 39);
      step(); exp_grant("t2_g3", 3);
      step(); exp_grant("t2_g4", 10);
      req = '0;
      step(); exp_idle("t2_done");
      exp_perf("t2", 6, 0);

      // stalled offer held stable
      issue_ready = 1'b0; req = bitv(5);
      step(); exp_grant("t3_offer", 5);
      for (int k = 0; k < 4; k++) begin
         step(); exp_grant("t3_hold", 5);
      end
      exp_perf("t3", 6, 4);
      issue_ready = 1'b1; req = '0;
      step(); exp_idle("t3_done");
      exp_perf("t3_acc", 7, 4);

      // single requester re-grant, then flush beats accept
      req = bitv(7);
      step(); exp_grant("t4_g7", 7);
      step(); exp_idle("t4_excl");
      step(); exp_grant("t4_regrant", 7);
      flush = 1'b1;
      step(); exp_idle("t4_flush");
      exp_perf("t4", 8, 4);
      flush = 1'b0; req = bitv(6) | bitv(9);
      step(); exp_grant("t4_from8", 9);
      req = '0;
      step(); exp_idle("t4_done");
      exp_perf("t4_acc", 9, 4);

      // wrap after last_ptr = 39
      req = bitv(39);
      step(); exp_grant("t5_g39", 39);
      req = bitv(0) | bitv(38);
      step(); exp_grant("t5_wrap0", 0);
      step(); exp_grant("t5_g38", 38);
      req = '0;
      step(); exp_idle("t5_done");
      exp_perf("t5", 12, 4);

      // reset during an offer restarts the search at index 0
      issue_ready = 1'b0; req = bitv(20);
      step(); exp_grant("t6_g20", 20);
      rst = 1'b1;
      step(); exp_idle("t6_rst");
      chk("t6_rst_id", 64'(gnt_id), 64'd0);
      exp_perf("t6_rst", 0, 0);
      rst = 1'b0; req = bitv(20) | bitv(39);
      step(); exp_grant("t6_restart", 20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
